aes_key_sched: RTL and testbench

Parametrised, word-serial AES key schedule for AES-128/192/256, selected per key at run time. It generates one 32-bit schedule word per cycle and streams 128-bit round keys (index 0..Nr) over a valid/ready interface with backpressure. It feeds the round datapath of the AES engine and reuses the team's existing `sbox` byte-substitution module; Rcon is generated internally.

---
 rtl/aes_key_sched_if.sv | 26 ++
 rtl/aes_key_sched.sv | 203 ++++++++++++++++++++
 tb/tb_aes_key_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_if.sv
// Start/key request and round-key stream of the AES key schedule.
// The schedule block sits on the slave side; the round datapath or a bench drives the master side.
interface aes_key_sched_if #(
    parameter int RK_IDX_W = 4
);
    logic                start;
    logic [1:0]          key_len;
    logic [255:0]        key;
    logic                busy;
    logic                rk_valid;
    logic                rk_ready;
    logic [127:0]        rk_data;
    logic [RK_IDX_W-1:0] rk_idx;
    logic                rk_last;
    logic                done;

    modport master (
        output start, key_len, key, rk_ready,
        input  busy, rk_valid, rk_data, rk_idx, rk_last, done
    );

    modport slave (
        input  start, key_len, key, rk_ready,
        output busy, rk_valid, rk_data, rk_idx, rk_last, done
    );
endinterface

// File: rtl/aes_key_sched.sv
// Word-serial AES key schedule: one 32-bit word per cycle, 128-bit round keys out over valid/ready.
// AES_KEY_256_EN compiles in the 192/256-bit modes; without it only AES-128 is built.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero for free.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign y = affine(ginv(a));
endmodule

module aes_key_sched #(
    parameter int RK_IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_key_sched_if.slave  bus
);
`ifdef AES_KEY_256_EN
    localparam int WIN = 8;
`else
    localparam int WIN = 4;
`endif
    localparam int KEY_W = 32 * WIN;

    typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                  state, state_nx;
    logic [KEY_W-1:0]        key_q;
    logic [WIN-1:0][31:0]    win;
    logic [2:0][31:0]        abuf;
    logic [1:0]              bcnt;
    logic [5:0]              wcnt;
    logic [2:0]              imod;
    logic [7:0]              rcon;
    logic [2:0]              nk_m1;
    logic [3:0]              nr;
    logic [RK_IDX_W-1:0]     rk_cnt;
    logic [RK_IDX_W-1:0]     rk_idx;
    logic [127:0]            rk_data;
    logic                    rk_valid, rk_last, done;
    logic                    start_acc, key_phase, last_word, gen, xfer, hs;
    logic [31:0]             w_prev, w_old, sb_in, sb_out, t, w_new;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    assign start_acc = (state == IDLE) && bus.start;

`ifdef AES_KEY_256_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nk_m1 <= 3'd3;
            nr    <= 4'd10;
        end else if (start_acc) begin
            case (bus.key_len)
                2'b01:   begin nk_m1 <= 3'd5; nr <= 4'd12; end
                2'b10:   begin nk_m1 <= 3'd7; nr <= 4'd14; end
                default: begin nk_m1 <= 3'd3; nr <= 4'd10; end
            endcase
        end
    end
    assign w_old = win[nk_m1];
`else
    logic unused_in;
    assign unused_in = ^{bus.key_len, bus.key[127:0]};
    assign nk_m1     = 3'd3;
    assign nr        = 4'd10;
    assign w_old     = win[3];
`endif

    assign key_phase = wcnt <= {3'd0, nk_m1};
    assign last_word = wcnt == ({nr, 2'b00} + 6'd3);
    assign w_prev    = win[0];
    assign sb_in     = (imod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox u_sbox (.a(sb_in[8*b +: 8]), .y(sb_out[8*b +: 8]));
    end

    always_comb begin
        t = w_prev;
        if (imod == 3'd0)
            t = sb_out ^ {rcon, 24'h0};
`ifdef AES_KEY_256_EN
        else if (nk_m1 == 3'd7 && imod == 3'd4)
            t = sb_out;
`endif
    end

    assign w_new = key_phase ? key_q[KEY_W-1 -: 32] : (w_old ^ t);
    assign hs    = rk_valid && bus.rk_ready;
    // The 4th word of a round key is only produced when it can move straight to the output.
    assign gen   = (state == GEN) && ((bcnt != 2'd3) || !rk_valid || bus.rk_ready);
    assign xfer  = gen && (bcnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start)          state_nx = GEN;
            GEN:     if (gen && last_word)   state_nx = DRAIN;
            DRAIN:   if (hs && rk_last)      state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
            win   <= '0;
            abuf  <= '0;
            bcnt  <= 2'd0;
            wcnt  <= 6'd0;
            imod  <= 3'd0;
            rcon  <= 8'h01;
        end else if (start_acc) begin
            key_q <= bus.key[255 -: KEY_W];
            bcnt  <= 2'd0;
            wcnt  <= 6'd0;
            imod  <= 3'd0;
            rcon  <= 8'h01;
        end else if (gen) begin
            key_q <= {key_q[KEY_W-33:0], 32'h0};
            win   <= {win[WIN-2:0], w_new};
            wcnt  <= wcnt + 6'd1;
            imod  <= (imod == nk_m1) ? 3'd0 : imod + 3'd1;
            if (!key_phase && imod == 3'd0)
                rcon <= xtime(rcon);
            if (bcnt == 2'd3) begin
                bcnt <= 2'd0;
            end else begin
                abuf <= {abuf[1:0], w_new};
                bcnt <= bcnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_data  <= '0;
            rk_idx   <= '0;
            rk_last  <= 1'b0;
            rk_valid <= 1'b0;
            rk_cnt   <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == DRAIN) && hs && rk_last;
            if (start_acc)
                rk_cnt <= '0;
            else if (xfer)
                rk_cnt <= rk_cnt + RK_IDX_W'(1);
            if (xfer) begin
                rk_data  <= {abuf[2], abuf[1], abuf[0], w_new};
                rk_idx   <= rk_cnt;
                rk_last  <= rk_cnt == RK_IDX_W'(nr);
                rk_valid <= 1'b1;
            end else if (hs) begin
                rk_valid <= 1'b0;
            end
        end
    end

    assign bus.busy     = state != IDLE;
    assign bus.rk_valid = rk_valid;
    assign bus.rk_data  = rk_data;
    assign bus.rk_idx   = rk_idx;
    assign bus.rk_last  = rk_last;
    assign bus.done     = done;
endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: FIPS-197 key expansion model, per-cycle stream monitor, random keys and backpressure.
module tb_aes_key_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_sched_if #(.RK_IDX_W(4)) bus();
    aes_key_sched #(.RK_IDX_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    logic [7:0]   sb [256];
    logic [127:0] exp_rk [15];
    int           exp_nr;
    bit           mon_active = 0, sched_done = 0, rnd_ready = 0, timing = 0;
    bit           first_seen = 0, prev_stall = 0;
    int           s_cyc = 0, hs_cnt = 0, last_rel = 0;
    logic [127:0] first_data, last_data, prev_data;
    logic [3:0]   prev_idx;
    logic         prev_last;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic gen_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    function automatic logic [7:0] rc(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int j = 1; j < n; j++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        return r;
    endfunction

    task automatic build_exp(input logic [255:0] k, input logic [1:0] len);
        logic [31:0] w [60];
        logic [31:0] tt;
        int nk;
        nk = 4;
`ifdef AES_KEY_256_EN
        if (len == 2'b01) nk = 6;
        if (len == 2'b10) nk = 8;
`endif
        exp_nr = nk + 6;
        for (int i = 0; i < 4 * (exp_nr + 1); i++) begin
            if (i < nk) begin
                w[i] = k[255 - 32*i -: 32];
            end else begin
                tt = w[i-1];
                if (i % nk == 0)
                    tt = subw({tt[23:0], tt[31:24]}) ^ {rc(i / nk), 24'h0};
                else if (nk == 8 && i % nk == 4)
                    tt = subw(tt);
                w[i] = w[i-nk] ^ tt;
            end
        end
        for (int r = 0; r <= exp_nr; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        bus.rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin : monitor
        int rel;
        forever begin
            @(negedge clk);
            if (mon_active) begin
                rel = cyc - s_cyc + 1;
                if (rel == 1) chk("busy_rise", bus.busy, 1);
                if (prev_stall) begin
                    chk("stall_valid", bus.rk_valid, 1);
                    chk("stall_data", bus.rk_data, prev_data);
                    chk("stall_idx", bus.rk_idx, prev_idx);
                    chk("stall_last", bus.rk_last, prev_last);
                end
                if (bus.rk_valid && !first_seen) begin
                    first_seen = 1;
                    chk("first_valid_cycle", rel, 5);
                end
                if (bus.rk_valid && bus.rk_ready) begin
                    if (hs_cnt > exp_nr) begin
                        chk("extra_handshake", hs_cnt, exp_nr);
                    end else begin
                        chk("rk_data", bus.rk_data, exp_rk[hs_cnt]);
                        chk("rk_idx", bus.rk_idx, hs_cnt);
                        chk("rk_last", bus.rk_last, hs_cnt == exp_nr);
                    end
                    if (hs_cnt == 0) first_data = bus.rk_data;
                    last_data = bus.rk_data;
                    if (bus.rk_last) begin
                        last_rel = rel;
                        if (timing) chk("last_cycle", rel, 4 * exp_nr + 5);
                    end
                    hs_cnt++;
                end
                if (bus.done) begin
                    chk("handshake_count", hs_cnt, exp_nr + 1);
                    chk("busy_fall", bus.busy, 0);
                    chk("done_cycle", rel, last_rel + 1);
                    mon_active = 0;
                    sched_done = 1;
                end
                prev_stall = bus.rk_valid && !bus.rk_ready;
                prev_data  = bus.rk_data;
                prev_idx   = bus.rk_idx;
                prev_last  = bus.rk_last;
            end else if (rst_n && bus.done) begin
                chk("stray_done", bus.done, 0);
            end
        end
    end

    task automatic launch(input logic [255:0] k, input logic [1:0] len, input bit rnd);
        build_exp(k, len);
        rnd_ready  = rnd;
        timing     = !rnd;
        hs_cnt     = 0;
        first_seen = 0;
        prev_stall = 0;
        sched_done = 0;
        last_rel   = 0;
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.key     = k;
        bus.key_len = len;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        s_cyc      = cyc;
        mon_active = 1;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 3000 && !sched_done; n++) @(posedge clk);
        if (!sched_done) begin
            chk("schedule_timeout", 0, 1);
            mon_active = 0;
        end
    endtask

    task automatic wait_rel(input int r);
        while (cyc - s_cyc + 1 < r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.rk_valid, 0);
        chk("rst_data", bus.rk_data, 0);
        chk("rst_idx", bus.rk_idx, 0);
        chk("rst_last", bus.rk_last, 0);
        chk("rst_done", bus.done, 0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.key      = '0;
        bus.key_len  = 2'b00;
        bus.rk_ready = 1'b1;
        gen_sbox();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1'b1;

        build_exp(K128, 2'b00);
        chk("model_aes128_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        launch(K128, 2'b00, 0);
        wait_done();
        chk("aes128_rk0", first_data, K128[255:128]);
        chk("aes128_rk10", last_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEY_256_EN
        build_exp(K192, 2'b01);
        chk("model_aes192_rk12", exp_rk[12], 128'he98ba06f448c773c8ecc720401002202);
        launch(K192, 2'b01, 0);
        wait_done();
        chk("aes192_rk12", last_data, 128'he98ba06f448c773c8ecc720401002202);
        chk("aes192_hs", hs_cnt, 13);

        build_exp(K256, 2'b10);
        chk("model_aes256_rk14", exp_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
        launch(K256, 2'b10, 0);
        wait_done();
        chk("aes256_rk14", last_data, 128'hfe4890d1e6188d0b046df344706c631e);
        chk("aes256_hs", hs_cnt, 15);
`else
        launch(K128, 2'b01, 0);
        wait_done();
        chk("keylen_ignored_rk10", last_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

        launch(K128, 2'b00, 1);
        wait_done();
        chk("backpressure_rk10", last_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        launch(K128, 2'b00, 0);
        wait_rel(20);
        bus.start = 1'b1;
        bus.key   = K256;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();
        chk("busy_start_rk10", last_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        launch(K256, 2'b10, 0);
        wait_rel(15);
        rst_n      = 1'b0;
        mon_active = 0;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        launch(K128, 2'b00, 0);
        wait_done();
        chk("post_reset_rk0", first_data, K128[255:128]);
        chk("post_reset_rk10", last_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int n = 0; n < 6; n++) begin
            logic [255:0] k;
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            launch(k, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
